// File: rtl/clock_pkg.sv
// Shared constants and helpers for the clock blocks.
// Optional BCD outputs are enabled by SEC_COUNTER_BCD_OUT_EN.
package clock_pkg;

    localparam int SEC_W      = 6;
    localparam int BCD_W      = 4;
    localparam int CLK_HZ_DEF = 50000000;

    typedef logic [SEC_W-1:0] sec_t;
    typedef logic [BCD_W-1:0] bcd_t;

    localparam sec_t SEC_MAX = 6'd59;

    // Wraps at 59, never at the natural 6-bit limit.
    function automatic sec_t sec_inc(input sec_t s);
        return (s == SEC_MAX) ? '0 : s + SEC_W'(1);
    endfunction

    function automatic bcd_t to_tens(input sec_t s);
        return BCD_W'(s / 6'd10);
    endfunction

    function automatic bcd_t to_units(input sec_t s);
        return BCD_W'(s % 6'd10);
    endfunction

endpackage

// File: rtl/sec_counter_tick_gen.sv
// Free-running prescaler: counts 0..TC while enabled, pulses tick at TC.
// Shared with the minutes and hours blocks.
module tick_gen #(
    parameter int TC = 49999999
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (TC > 0) ? $clog2(TC + 1) : 1;
    localparam logic [W-1:0] TCV = W'(TC);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == TCV);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TCV) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/sec_counter.sv
// Seconds counter 0..59 with load, adjust and minute carry pulse.
// SEC_COUNTER_BCD_OUT_EN adds registered BCD digit outputs.
module sec_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEF,
    parameter int SIM_DIV = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             load,
    input  logic [SEC_W-1:0] set_val,
    input  logic             adj,
    output logic [SEC_W-1:0] data,
    output logic             sec_tick,
    output logic             min_tick,
`ifdef SEC_COUNTER_BCD_OUT_EN
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_units,
`endif
    output logic             load_err
);

    localparam int TC = (SIM_DIV != 0) ? SIM_DIV - 1 : CLK_HZ - 1;

    logic tick;
    logic load_ok;

    assign load_ok = load && (set_val <= SEC_MAX);

    tick_gen #(
        .TC(TC)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (run),
        .clr  (load_ok),
        .tick (tick)
    );

    // Valid load wins, then adj; a tick lost to either is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data     <= '0;
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            load_err <= load && !load_ok;
            if (load_ok) begin
                data <= set_val;
            end else if (adj) begin
                data <= sec_inc(data);
            end else if (tick) begin
                data     <= sec_inc(data);
                sec_tick <= 1'b1;
                min_tick <= (data == SEC_MAX);
            end
        end
    end

`ifdef SEC_COUNTER_BCD_OUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_tens  <= '0;
            bcd_units <= '0;
        end else begin
            bcd_tens  <= to_tens(data);
            bcd_units <= to_units(data);
        end
    end
`endif

endmodule

// File: tb/tb_sec_counter.sv
// Scoreboard bench for sec_counter with a behavioural seconds model.
// Build with SEC_COUNTER_BCD_OUT_EN to also check the BCD outputs.
module tb_sec_counter;

    localparam int DIV = 4;

    typedef struct {
        int d;
        bit st;
        bit mt;
        bit le;
        int tens;
        int units;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [5:0] set_val = '0;
    logic       adj = 1'b0;
    logic [5:0] data;
    logic       sec_tick;
    logic       min_tick;
    logic       load_err;
`ifdef SEC_COUNTER_BCD_OUT_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
`endif

    int checks = 0;
    int fails = 0;

    exp_t sb[$];

    // Reference state: seconds value, cycles into the current second.
    int m_sec = 0;
    int m_phase = 0;
    int m_prev = 0;

    always #5 clk = ~clk;

    sec_counter #(
        .CLK_HZ (1000),
        .SIM_DIV(DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .load     (load),
        .set_val  (set_val),
        .adj      (adj),
        .data     (data),
        .sec_tick (sec_tick),
        .min_tick (min_tick),
`ifdef SEC_COUNTER_BCD_OUT_EN
        .bcd_tens (bcd_tens),
        .bcd_units(bcd_units),
`endif
        .load_err (load_err)
    );

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            bit bad;
            e = sb.pop_front();
            bad = (int'(data) != e.d) || (sec_tick != e.st) ||
                  (min_tick != e.mt) || (load_err != e.le);
`ifdef SEC_COUNTER_BCD_OUT_EN
            bad = bad || (int'(bcd_tens) != e.tens) ||
                  (int'(bcd_units) != e.units);
`endif
            checks++;
            if (bad) begin
                fails++;
                $display("FAIL cycle t=%0t got d=%0d st=%0b mt=%0b le=%0b want d=%0d st=%0b mt=%0b le=%0b tens=%0d units=%0d",
                         $time, data, sec_tick, min_tick, load_err,
                         e.d, e.st, e.mt, e.le, e.tens, e.units);
            end
        end
    end

    // One clock cycle: drive inputs, predict the result of the next edge.
    task automatic cyc(input bit r, input bit ld, input int sv,
                       input bit a);
        exp_t e;
        bit tk;
        bit ok;
        @(negedge clk);
        run = r;
        load = ld;
        set_val = 6'(sv);
        adj = a;
        ok = ld && (sv <= 59);
        tk = r && (m_phase == DIV - 1);
        e.st = 0;
        e.mt = 0;
        e.le = ld && !ok;
        e.tens = m_prev / 10;
        e.units = m_prev % 10;
        if (ok) m_phase = 0;
        else if (r) m_phase = (m_phase + 1) % DIV;
        if (ok) begin
            m_sec = sv;
        end else if (a) begin
            m_sec = (m_sec + 1) % 60;
        end else if (tk) begin
            e.st = 1;
            e.mt = (m_sec == 59);
            m_sec = (m_sec + 1) % 60;
        end
        e.d = m_sec;
        m_prev = m_sec;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (data != 0 || sec_tick || min_tick || load_err) begin
            fails++;
            $display("FAIL %s got d=%0d st=%0b mt=%0b le=%0b want all 0",
                     name, data, sec_tick, min_tick, load_err);
        end
`ifdef SEC_COUNTER_BCD_OUT_EN
        checks++;
        if (bcd_tens != 0 || bcd_units != 0) begin
            fails++;
            $display("FAIL %s_bcd got %0d%0d want 00", name,
                     bcd_tens, bcd_units);
        end
`endif
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b0;
        run = 1'b0;
        load = 1'b0;
        adj = 1'b0;
        #1;
        check_zero(name);
        @(negedge clk);
        reset = 1'b1;
        m_sec = 0;
        m_phase = 0;
        m_prev = 0;
    endtask

    initial begin
        #1;
        check_zero("reset_init");
        #20;
        @(negedge clk);
        reset = 1'b1;

        // Free run through a full minute wrap.
        repeat (250) cyc(1, 0, 0, 0);

        // Load 58 and run across the wrap.
        cyc(0, 1, 58, 0);
        repeat (10) cyc(1, 0, 0, 0);

        // Invalid load while at 12.
        cyc(1, 1, 12, 0);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 1, 60, 0);
        repeat (6) cyc(1, 0, 0, 0);
        cyc(1, 1, 63, 1);
        repeat (6) cyc(1, 0, 0, 0);

        // Adjust at 59, then load beats adj.
        cyc(0, 1, 59, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 30, 1);
        cyc(0, 0, 0, 0);

        // Hold mid-period, then resume.
        cyc(1, 1, 20, 0);
        repeat (2) cyc(1, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0);
        repeat (8) cyc(1, 0, 0, 0);

        // Asynchronous reset mid-period with data at 37.
        cyc(1, 1, 37, 0);
        cyc(1, 0, 0, 0);
        do_reset("reset_mid");
        repeat (9) cyc(1, 0, 0, 0);

        cyc(0, 1, 47, 0);
        repeat (2) cyc(0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            bit r;
            bit ld;
            bit a;
            r = ($urandom_range(0, 9) < 8);
            ld = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 14) == 0);
            cyc(r, ld, int'($urandom_range(0, 63)), a);
        end
        cyc(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
